// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
//
// Shared definitions for the AXI4 DMA read master:
//   - dma_rd_state_t : command FSM states
//   - AXI_BURST_INCR : AXI burst type used for every AR
//   - AXI_RESP_OKAY  : the only response that does not flag an error
//   - AXI_4K         : AXI page size that a burst may never cross
//   - calc_burst_len : beats for the next burst, limited by the maximum
//                      burst length, the beats still owed to the command,
//                      and the room left before the next 4 KB boundary
// ---------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dma_rd_state_t;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned AXI_4K         = 4096;

    // Only the page offset of the address matters for the boundary limit.
    // The result is at most 255 here (beats_left is 8 bits) but is kept
    // 9 bits wide so a 256-beat maximum still fits.
    function automatic logic [8:0] calc_burst_len(
        input logic [11:0]  addr,
        input logic [7:0]   beats_left,
        input int unsigned  max_burst,
        input int unsigned  bpb
    );
        int unsigned room;
        int unsigned len;
        room = (AXI_4K - 32'(addr)) / bpb;
        len  = max_burst;
        if (32'(beats_left) < len) len = 32'(beats_left);
        if (room < len)            len = room;
        return len[8:0];
    endfunction

endpackage

// File: rtl/axi_dma_reader.sv
// ---------------------------------------------------------------------------
// axi_dma_reader
//
// AXI4 read master feeding tile_loader. One command at a time: a start byte
// address and a beat count. The command is split into INCR bursts that never
// cross a 4 KB page, with at most MAX_OUTSTANDING bursts in flight, and every
// returned beat is forwarded one cycle later on rd_data/rd_data_vld. The
// consumer cannot stall, so rready is held high whenever a command is active.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   rd_start_dma      one-cycle command pulse (ignored while rd_busy)
//   rd_start_addr     start byte address (low beat-offset bits dropped)
//   rd_num_trans      beats to read, 0..255
//   rd_busy           command in progress
//   rd_done           one-cycle completion pulse
//   rd_data/_vld      forwarded read beat
//   rd_err            sticky error flag, set by any non-OKAY rresp,
//                     cleared by the next accepted command
//   m_axi_ar*         AXI4 read address channel (master side)
//   m_axi_r*          AXI4 read data channel (master side)
// ---------------------------------------------------------------------------
module axi_dma_reader
    import dma_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              rd_start_dma,
    input  logic [ADDR_W-1:0] rd_start_addr,
    input  logic [7:0]        rd_num_trans,
    output logic              rd_busy,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              rd_err,

    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int BPB      = DATA_W / 8;
    localparam int BPB_LOG2 = $clog2(BPB);
    localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [OUT_W-1:0]  OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
    localparam logic [2:0]        ARSIZE     = 3'(BPB_LOG2);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BPB) - ADDR_W'(1));

    dma_rd_state_t     state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [7:0]        beats_left_q, beats_left_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic              rd_err_q, rd_err_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_data_vld_q;

    logic [8:0]        blen;
    logic [ADDR_W-1:0] blen_bytes;
    logic              ar_valid;
    logic              ar_hs;
    logic              r_hs;
    logic              r_last_hs;

    // The next burst is sized purely from registered state, so the AR fields
    // cannot move while arvalid waits for arready. Once arvalid rises it can
    // only fall through a handshake: without one the outstanding count can
    // only go down, so the cap stays satisfied.
    assign blen       = calc_burst_len(cur_addr_q[11:0], beats_left_q,
                                       MAX_BURST, BPB);
    assign blen_bytes = ADDR_W'(blen) << BPB_LOG2;
    assign ar_valid   = (state_q == ST_ISSUE) && (outstanding_q < OUT_MAX);
    assign ar_hs      = ar_valid && m_axi_arready;
    assign r_hs       = m_axi_rvalid && m_axi_rready;
    assign r_last_hs  = r_hs && m_axi_rlast;

    // Command FSM, burst splitter, outstanding counter and error flag.
    // A zero-length command takes no AR; it passes through DRAIN (which sees
    // nothing outstanding) so rd_done lands two cycles after the command,
    // the same spacing as the last rlast to rd_done on a normal command.
    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        beats_left_d  = beats_left_q;
        outstanding_d = outstanding_q;
        rd_err_d      = rd_err_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_start_dma) begin
                    cur_addr_d   = rd_start_addr & ALIGN_MASK;
                    beats_left_d = rd_num_trans;
                    rd_err_d     = 1'b0;
                    state_d      = (rd_num_trans == 8'd0) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ar_hs) begin
                    cur_addr_d   = cur_addr_q + blen_bytes;
                    beats_left_d = beats_left_q - blen[7:0];
                    if (beats_left_q == blen[7:0]) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An AR accept and a burst completion in the same cycle cancel out.
        case ({ar_hs, r_last_hs})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        // rready is low in IDLE, so this never collides with the clear above.
        if (r_hs && (m_axi_rresp != AXI_RESP_OKAY)) begin
            rd_err_d = 1'b1;
        end
    end

    // State registers. Reset abandons any command in flight without a
    // completion pulse; the slave side is expected to be reset alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cur_addr_q    <= '0;
            beats_left_q  <= '0;
            outstanding_q <= '0;
            rd_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            beats_left_q  <= beats_left_d;
            outstanding_q <= outstanding_d;
            rd_err_q      <= rd_err_d;
        end
    end

    // Registered beat forwarding: every accepted beat, error or not, appears
    // on rd_data one cycle after its R handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q     <= '0;
            rd_data_vld_q <= 1'b0;
        end else begin
            rd_data_vld_q <= r_hs;
            if (r_hs) begin
                rd_data_q <= m_axi_rdata;
            end
        end
    end

    // AR fields are forced to zero whenever no request is being presented.
    assign m_axi_arvalid = ar_valid;
    assign m_axi_araddr  = ar_valid ? cur_addr_q : '0;
    assign m_axi_arlen   = ar_valid ? 8'(blen - 9'd1) : 8'd0;
    assign m_axi_arsize  = ARSIZE;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_rready  = (state_q != ST_IDLE);

    assign rd_busy     = (state_q != ST_IDLE);
    assign rd_done     = (state_q == ST_DONE);
    assign rd_data     = rd_data_q;
    assign rd_data_vld = rd_data_vld_q;
    assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_axi_dma_reader.sv
// ---------------------------------------------------------------------------
// tb_axi_dma_reader
//
// Directed bench for axi_dma_reader. A small AXI slave answers each AR with
// data derived from the beat address; expected ARs and expected forwarded
// beats are queued when a command is issued and popped as the DUT produces
// them. Inputs change #1/#2 after the rising edge, the AXI/monitor process
// samples on the falling edge, and the main sequence samples at +#3.
// ---------------------------------------------------------------------------
module tb_axi_dma_reader;

    logic        clk;
    logic        rst;
    logic        rd_start_dma;
    logic [31:0] rd_start_addr;
    logic [7:0]  rd_num_trans;
    logic        rd_busy;
    logic        rd_done;
    logic [31:0] rd_data;
    logic        rd_data_vld;
    logic        rd_err;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    axi_dma_reader #(
        .ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_start_dma(rd_start_dma), .rd_start_addr(rd_start_addr),
        .rd_num_trans(rd_num_trans), .rd_busy(rd_busy), .rd_done(rd_done),
        .rd_data(rd_data), .rd_data_vld(rd_data_vld), .rd_err(rd_err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    // Scoreboard and bookkeeping
    int          vectors = 0;
    int          miscompares = 0;
    int          cycleNum = 0;
    logic [31:0] expDataQ[$];
    logic [31:0] expArAddrQ[$];
    int          expArLenQ[$];
    logic [31:0] burstAddrQ[$];
    int          burstLenQ[$];

    int   doneCount, arTotal, arBeforeRlast, beatCount;
    int   startCycle, firstArCycle, lastRlastCycle, doneCycle;
    logic seenRlast, firstArSeen, errAtDone;
    int   rHold = 0;
    int   errBeatIdx = -1;
    int   cmdBeat = 0;
    int   beatIdx = 0;
    logic flushReq = 1'b0;
    logic rHsPrev, rLastPrev;

    function automatic logic [31:0] beatData(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Every comparison goes through here so counting and reporting agree.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycleNum++;
        end
    end

    // AXI slave plus output monitor. On the falling edge it records what
    // handshakes will complete at the next rising edge and checks forwarded
    // beats; just after the rising edge it presents the next R beat.
    initial begin
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            if (m_axi_arvalid && m_axi_arready) begin
                arTotal++;
                if (!seenRlast) arBeforeRlast++;
                checkOutput("ar_expected_pending", 32'(expArAddrQ.size() != 0), 32'd1);
                if (expArAddrQ.size() != 0) begin
                    checkOutput("araddr", m_axi_araddr, expArAddrQ.pop_front());
                    checkOutput("arlen", {24'd0, m_axi_arlen}, 32'(expArLenQ.pop_front()));
                end
                burstAddrQ.push_back(m_axi_araddr);
                burstLenQ.push_back(int'(m_axi_arlen));
            end
            if (m_axi_arvalid && !firstArSeen) begin
                firstArSeen  = 1'b1;
                firstArCycle = cycleNum;
            end
            rHsPrev   = m_axi_rvalid && m_axi_rready;
            rLastPrev = m_axi_rlast;
            if (rHsPrev && rLastPrev) begin
                seenRlast      = 1'b1;
                lastRlastCycle = cycleNum;
            end
            if (rd_data_vld) begin
                beatCount++;
                checkOutput("data_expected_pending", 32'(expDataQ.size() != 0), 32'd1);
                if (expDataQ.size() != 0) begin
                    checkOutput("rd_data", rd_data, expDataQ.pop_front());
                end
            end
            if (rd_done) begin
                doneCount++;
                doneCycle = cycleNum;
                errAtDone = rd_err;
            end
            if (rd_start_dma && !rd_busy) startCycle = cycleNum;

            @(posedge clk);
            #1;
            if (flushReq) begin
                burstAddrQ.delete();
                burstLenQ.delete();
                beatIdx      = 0;
                rHold        = 0;
                flushReq     = 1'b0;
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
            end else begin
                if (rHsPrev) begin
                    cmdBeat++;
                    if (rLastPrev) begin
                        void'(burstAddrQ.pop_front());
                        void'(burstLenQ.pop_front());
                        beatIdx = 0;
                    end else begin
                        beatIdx++;
                    end
                end
                if (rHold > 0) begin
                    rHold--;
                    m_axi_rvalid = 1'b0;
                end else if (burstAddrQ.size() != 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = beatData(burstAddrQ[0] + 32'(4 * beatIdx));
                    m_axi_rlast  = (beatIdx == burstLenQ[0]);
                    m_axi_rresp  = (cmdBeat == errBeatIdx) ? 2'b10 : 2'b00;
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                end
            end
        end
    end

    task automatic expectAr(input logic [31:0] addr, input int len);
        expArAddrQ.push_back(addr);
        expArLenQ.push_back(len);
    endtask

    // Pulses one command; returns at +#2 of the cycle after the pulse.
    task automatic applyStimulus(input logic [31:0] addr, input int num);
        @(posedge clk);
        #2;
        rd_start_addr = addr;
        rd_num_trans  = 8'(num);
        rd_start_dma  = 1'b1;
        @(posedge clk);
        #2;
        rd_start_dma  = 1'b0;
    endtask

    task automatic runCmd(input logic [31:0] addr, input int num,
                          input int hold, input int errBeat);
        logic [31:0] base;
        base           = addr & 32'hFFFF_FFFC;
        doneCount      = 0;
        arTotal        = 0;
        arBeforeRlast  = 0;
        beatCount      = 0;
        seenRlast      = 1'b0;
        firstArSeen    = 1'b0;
        firstArCycle   = -1;
        lastRlastCycle = -1;
        doneCycle      = -1;
        cmdBeat        = 0;
        rHold          = hold;
        errBeatIdx     = errBeat;
        for (int i = 0; i < num; i++) expDataQ.push_back(beatData(base + 32'(4 * i)));
        applyStimulus(addr, num);
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (doneCount == 0 && n < budget) begin
            @(posedge clk);
            #3;
            n++;
        end
        checkOutput("done_seen", 32'(doneCount != 0), 32'd1);
    endtask

    // Called at +#3 of the cycle after rd_done (three cycles after final rlast).
    task automatic checkCompletion(input string name, input int expArs, input int num,
                                   input logic expErr);
        checkOutput({name, "_done_count"}, 32'(doneCount), 32'd1);
        checkOutput({name, "_ar_count"}, 32'(arTotal), 32'(expArs));
        checkOutput({name, "_beats"}, 32'(beatCount), 32'(num));
        checkOutput({name, "_data_left"}, 32'(expDataQ.size()), 32'd0);
        checkOutput({name, "_ar_left"}, 32'(expArAddrQ.size()), 32'd0);
        checkOutput({name, "_err_at_done"}, {31'd0, errAtDone}, {31'd0, expErr});
        checkOutput({name, "_err_after"}, {31'd0, rd_err}, {31'd0, expErr});
        checkOutput({name, "_busy_after"}, {31'd0, rd_busy}, 32'd0);
        if (num != 0) begin
            checkOutput({name, "_first_ar_latency"}, 32'(firstArCycle - startCycle), 32'd1);
            checkOutput({name, "_done_latency"}, 32'(doneCycle - lastRlastCycle), 32'd2);
        end else begin
            checkOutput({name, "_done_latency"}, 32'(doneCycle - startCycle), 32'd2);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_arvalid"}, {31'd0, m_axi_arvalid}, 32'd0);
        checkOutput({name, "_araddr"}, m_axi_araddr, 32'd0);
        checkOutput({name, "_arlen"}, {24'd0, m_axi_arlen}, 32'd0);
        checkOutput({name, "_rready"}, {31'd0, m_axi_rready}, 32'd0);
        checkOutput({name, "_busy"}, {31'd0, rd_busy}, 32'd0);
        checkOutput({name, "_done"}, {31'd0, rd_done}, 32'd0);
        checkOutput({name, "_vld"}, {31'd0, rd_data_vld}, 32'd0);
        checkOutput({name, "_rd_data"}, rd_data, 32'd0);
        checkOutput({name, "_err"}, {31'd0, rd_err}, 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        rd_start_dma  = 1'b0;
        rd_start_addr = '0;
        rd_num_trans  = '0;
        repeat (3) @(posedge clk);
        #3;
        checkAllZero("reset");
        checkOutput("arsize", {29'd0, m_axi_arsize}, 32'd2);
        checkOutput("arburst", {30'd0, m_axi_arburst}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;

        $display("[TB] single burst");
        expectAr(32'h1000, 15);
        runCmd(32'h1000, 16, 0, -1);
        waitDone(500);
        checkCompletion("single", 1, 16, 1'b0);

        $display("[TB] split into three bursts");
        expectAr(32'h2000, 15);
        expectAr(32'h2040, 15);
        expectAr(32'h2080, 7);
        runCmd(32'h2000, 40, 0, -1);
        waitDone(500);
        checkCompletion("split", 3, 40, 1'b0);

        $display("[TB] 4 KB boundary");
        expectAr(32'h0FF0, 3);
        expectAr(32'h1000, 11);
        runCmd(32'h0FF0, 16, 0, -1);
        waitDone(500);
        checkCompletion("cross4k", 2, 16, 1'b0);

        $display("[TB] outstanding cap");
        for (int i = 0; i < 6; i++) expectAr(32'(i * 64), 15);
        runCmd(32'h0, 96, 30, -1);
        waitDone(1000);
        checkCompletion("cap", 6, 96, 1'b0);
        checkOutput("cap_ar_before_rlast", 32'(arBeforeRlast), 32'd4);

        $display("[TB] slave error and ignored second command");
        expectAr(32'h5000, 7);
        runCmd(32'h5000, 8, 0, 3);
        repeat (2) @(posedge clk);
        #2;
        rd_start_addr = 32'h6000;
        rd_num_trans  = 8'd4;
        rd_start_dma  = 1'b1;
        @(posedge clk);
        #2;
        rd_start_dma  = 1'b0;
        waitDone(500);
        checkCompletion("error", 1, 8, 1'b1);

        $display("[TB] zero-length command clears error");
        runCmd(32'h7000, 0, 0, -1);
        #1;
        checkOutput("zero_err_cleared", {31'd0, rd_err}, 32'd0);
        waitDone(100);
        checkCompletion("zero", 0, 0, 1'b0);

        $display("[TB] reset during drain");
        expectAr(32'h3000, 15);
        expectAr(32'h3040, 15);
        runCmd(32'h3000, 32, 30, -1);
        repeat (6) @(posedge clk);
        #2;
        rst      = 1'b1;
        flushReq = 1'b1;
        @(posedge clk);
        #3;
        checkAllZero("midreset");
        checkOutput("midreset_ar_left", 32'(expArAddrQ.size()), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        expDataQ.delete();
        repeat (40) @(posedge clk);
        #3;
        checkOutput("midreset_no_done", 32'(doneCount), 32'd0);

        $display("[TB] unaligned start address after reset");
        expectAr(32'h8000, 4);
        runCmd(32'h8003, 5, 0, -1);
        waitDone(500);
        checkCompletion("unaligned", 1, 5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
